pipeline_stage_sequencer: RTL and testbench

Sequences one instruction at a time through the IF/ID/EX/MEM/WB stages of the multi-cycle CPU core. Drives the `pipeline_stage` and `cycle_count` inputs of the signal generation unit. Stretches EX and MEM for multi-cycle instructions (RET, RCALL, PUSH/POP), inserts memory wait states, and counts retired instructions. Sits between the decoder, the data-memory wait line and the control-signal generator.

---
 rtl/pipeline_stage_sequencer_if.sv | 74 +++++++
 rtl/pipeline_stage_sequencer.sv | 150 +++++++++++++++
 tb/tb_pipeline_stage_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/pipeline_stage_sequencer_if.sv
// ----------------------------------------------------------------------------
// pipeline_stage_sequencer_if
//
// Purpose:
//   Bundles the decoder-facing inputs and the stage/count outputs of the
//   pipeline stage sequencer into one interface.
//
// Parameters:
//   CNT_WIDTH     - width of the retired-instruction counter (default 16)
//
// Signals (direction seen from the sequencer, modport "slave"):
//   enable        in  1          - freezes the whole sequencer when low
//   ex_len        in  2          - EX cycles minus 1 (valid during ID)
//   mem_len       in  2          - MEM cycles minus 1 (valid during ID)
//   skip_mem      in  1          - instruction has no MEM stage (valid in ID)
//   mem_wait      in  1          - data memory not ready (meaningful in MEM)
//   pipeline_stage out STAGE_COUNT - current stage encoding
//   cycle_count   out 1          - LSB of cycle_index
//   cycle_index   out 2          - cycle number within the current stage
//   fetch_en      out 1          - high exactly in IF
//   instr_done    out 1          - high exactly in WB
//   instr_count   out CNT_WIDTH  - retired instruction count
//
// Modports:
//   master - decoder / control side (drives the inputs, observes outputs)
//   slave  - the sequencer itself
// ----------------------------------------------------------------------------
interface pipeline_stage_sequencer_if #(
    parameter int CNT_WIDTH = 16
);
    // Width of the stage encoding (IF/ID/EX/MEM/WB need three bits).
    localparam int STAGE_COUNT = 3;

    logic                   enable;
    logic [1:0]             ex_len;
    logic [1:0]             mem_len;
    logic                   skip_mem;
    logic                   mem_wait;

    logic [STAGE_COUNT-1:0] pipeline_stage;
    logic                   cycle_count;
    logic [1:0]             cycle_index;
    logic                   fetch_en;
    logic                   instr_done;
    logic [CNT_WIDTH-1:0]   instr_count;

    modport master (
        output enable,
        output ex_len,
        output mem_len,
        output skip_mem,
        output mem_wait,
        input  pipeline_stage,
        input  cycle_count,
        input  cycle_index,
        input  fetch_en,
        input  instr_done,
        input  instr_count
    );

    modport slave (
        input  enable,
        input  ex_len,
        input  mem_len,
        input  skip_mem,
        input  mem_wait,
        output pipeline_stage,
        output cycle_count,
        output cycle_index,
        output fetch_en,
        output instr_done,
        output instr_count
    );
endinterface

// File: rtl/pipeline_stage_sequencer.sv
// ----------------------------------------------------------------------------
// pipeline_stage_sequencer
//
// Purpose:
//   Walks one instruction at a time through IF/ID/EX/MEM/WB for the
//   multi-cycle core. EX and MEM are stretched by lengths latched from the
//   decoder during ID, MEM additionally inserts uncounted wait states while
//   data memory is busy, and every instruction leaving WB is counted.
//
// Parameters:
//   CNT_WIDTH - width of the retired-instruction counter (default 16)
//
// Ports:
//   clk    in  1 - core clock, rising edge
//   reset  in  1 - asynchronous, active-high
//   bus    slave modport of pipeline_stage_sequencer_if carrying enable,
//          ex_len, mem_len, skip_mem, mem_wait (in) and pipeline_stage,
//          cycle_count, cycle_index, fetch_en, instr_done, instr_count (out)
//
// Configuration:
//   SEQ_STAGE_SKIP_EN - when defined, skip_mem is latched in ID and lets an
//                       instruction go from EX straight to WB. When undefined
//                       skip_mem is ignored and every instruction visits MEM.
//
// Stage encodings: IF=0, ID=1, EX=2, MEM=3, WB=4.
// Every output is a register or a pure decode of registers; there is no
// combinational path from any input to any output.
// ----------------------------------------------------------------------------
module pipeline_stage_sequencer #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    pipeline_stage_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        STAGE_IF  = 3'd0,
        STAGE_ID  = 3'd1,
        STAGE_EX  = 3'd2,
        STAGE_MEM = 3'd3,
        STAGE_WB  = 3'd4
    } stage_e;

    stage_e               stage;
    logic [1:0]           cycle_index;
    logic [1:0]           ex_len_q;
    logic [1:0]           mem_len_q;
    logic [CNT_WIDTH-1:0] instr_count;
    logic                 ex_last;
    logic                 mem_last;
    logic                 skip_q;

    // Last repetition of the current stage, compared against the lengths
    // captured in ID so decoder changes later on cannot disturb the
    // instruction in flight.
    assign ex_last  = (cycle_index == ex_len_q);
    assign mem_last = (cycle_index == mem_len_q);

`ifdef SEQ_STAGE_SKIP_EN
    logic skip_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skip_reg <= 1'b0;
        end else if (bus.enable && stage == STAGE_ID) begin
            skip_reg <= bus.skip_mem;
        end
    end

    assign skip_q = skip_reg;
`else
    // No skip latch in this build: skip_mem is deliberately left unused.
    logic unused_skip_mem;

    assign unused_skip_mem = bus.skip_mem;
    assign skip_q          = 1'b0;
`endif

    // Main sequencer: state, per-stage cycle index, latched lengths and the
    // retired-instruction counter all move together in one process so that
    // enable=0 freezes everything in the same cycle.
    // NOTE: sequential state is written with non-blocking assignments only,
    // so every register samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage       <= STAGE_IF;
            cycle_index <= 2'd0;
            ex_len_q    <= 2'd0;
            mem_len_q   <= 2'd0;
            instr_count <= '0;
        end else if (bus.enable) begin
            case (stage)
                STAGE_IF: begin
                    stage       <= STAGE_ID;
                    cycle_index <= 2'd0;
                end

                STAGE_ID: begin
                    ex_len_q    <= bus.ex_len;
                    mem_len_q   <= bus.mem_len;
                    stage       <= STAGE_EX;
                    cycle_index <= 2'd0;
                end

                STAGE_EX: begin
                    if (ex_last) begin
                        stage       <= skip_q ? STAGE_WB : STAGE_MEM;
                        cycle_index <= 2'd0;
                    end else begin
                        cycle_index <= cycle_index + 2'd1;
                    end
                end

                STAGE_MEM: begin
                    // A wait cycle holds both the stage and the index; only
                    // cycles with the memory ready count toward mem_len.
                    if (!bus.mem_wait) begin
                        if (mem_last) begin
                            stage       <= STAGE_WB;
                            cycle_index <= 2'd0;
                        end else begin
                            cycle_index <= cycle_index + 2'd1;
                        end
                    end
                end

                STAGE_WB: begin
                    stage       <= STAGE_IF;
                    cycle_index <= 2'd0;
                    instr_count <= instr_count + CNT_WIDTH'(1);
                end

                default: begin
                    stage       <= STAGE_IF;
                    cycle_index <= 2'd0;
                end
            endcase
        end
    end

    // Outputs: registers or decodes of the registered stage.
    assign bus.pipeline_stage = stage;
    assign bus.cycle_index    = cycle_index;
    assign bus.cycle_count    = cycle_index[0];
    assign bus.fetch_en       = (stage == STAGE_IF);
    assign bus.instr_done     = (stage == STAGE_WB);
    assign bus.instr_count    = instr_count;

endmodule

// File: tb/tb_pipeline_stage_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pipeline_stage_sequencer
//
// Builds, for each instruction, the list of (stage, index) values the
// sequencer must show cycle by cycle from the instruction's lengths, the
// chosen freeze cycles and the chosen memory wait cycles, then drives the
// matching enable/mem_wait values and compares every cycle. Decoder inputs
// carry random junk outside the ID cycle to show they are latched.
// ----------------------------------------------------------------------------
module tb_pipeline_stage_sequencer;

    localparam int CW = 4;

    localparam logic [2:0] S_IF  = 3'd0;
    localparam logic [2:0] S_ID  = 3'd1;
    localparam logic [2:0] S_EX  = 3'd2;
    localparam logic [2:0] S_MEM = 3'd3;
    localparam logic [2:0] S_WB  = 3'd4;

    logic clk = 1'b0;
    logic reset;

    pipeline_stage_sequencer_if #(.CNT_WIDTH(CW)) bus ();

    pipeline_stage_sequencer #(.CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] stage;
        int         idx;
        bit         en;
        bit         wt;
    } step_t;

    step_t plan[$];
    int    tests     = 0;
    int    fails     = 0;
    int    exp_count = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Append one visible cycle of a stage, preceded by nfreeze frozen copies
    // and nwait memory-wait copies of the same cycle.
    task automatic push(input logic [2:0] st, input int idx, input int nfreeze, input int nwait);
        step_t s;
        for (int k = 0; k < nfreeze; k++) begin
            s.stage = st; s.idx = idx; s.en = 1'b0; s.wt = 1'($urandom_range(0, 1));
            plan.push_back(s);
        end
        for (int k = 0; k < nwait; k++) begin
            s.stage = st; s.idx = idx; s.en = 1'b1; s.wt = 1'b1;
            plan.push_back(s);
        end
        s.stage = st; s.idx = idx; s.en = 1'b1;
        s.wt    = (st == S_MEM) ? 1'b0 : 1'($urandom_range(0, 1));
        plan.push_back(s);
    endtask

    task automatic run_instr(input int ex, input int mem, input bit skip,
                             input int waits0, input int freeze_ex, input bit rnd);
        bit eff_skip;
        int fz;
        int wt;
`ifdef SEQ_STAGE_SKIP_EN
        eff_skip = skip;
`else
        eff_skip = 1'b0;
`endif
        plan.delete();
        fz = rnd ? int'($urandom_range(0, 1)) : 0;
        push(S_IF, 0, fz, 0);
        fz = rnd ? int'($urandom_range(0, 1)) : 0;
        push(S_ID, 0, fz, 0);
        for (int i = 0; i <= ex; i++) begin
            fz = rnd ? int'($urandom_range(0, 1)) : ((i == 0) ? freeze_ex : 0);
            push(S_EX, i, fz, 0);
        end
        if (!eff_skip) begin
            for (int i = 0; i <= mem; i++) begin
                fz = rnd ? int'($urandom_range(0, 1)) : 0;
                wt = rnd ? int'($urandom_range(0, 2)) : ((i == 0) ? waits0 : 0);
                push(S_MEM, i, fz, wt);
            end
        end
        fz = rnd ? int'($urandom_range(0, 1)) : 0;
        push(S_WB, 0, fz, 0);

        foreach (plan[n]) begin
            check($sformatf("stage[%0d]", n), 32'(bus.pipeline_stage), 32'(plan[n].stage));
            check($sformatf("cycle_index[%0d]", n), 32'(bus.cycle_index), plan[n].idx);
            check($sformatf("cycle_count[%0d]", n), 32'(bus.cycle_count), plan[n].idx % 2);
            check($sformatf("fetch_en[%0d]", n), 32'(bus.fetch_en), 32'(plan[n].stage == S_IF));
            check($sformatf("instr_done[%0d]", n), 32'(bus.instr_done), 32'(plan[n].stage == S_WB));
            check($sformatf("instr_count[%0d]", n), 32'(bus.instr_count), exp_count);
            bus.enable   = plan[n].en;
            bus.mem_wait = plan[n].wt;
            if (plan[n].stage == S_ID && plan[n].en) begin
                bus.ex_len   = 2'(ex);
                bus.mem_len  = 2'(mem);
                bus.skip_mem = skip;
            end else begin
                bus.ex_len   = 2'($urandom_range(0, 3));
                bus.mem_len  = 2'($urandom_range(0, 3));
                bus.skip_mem = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
            if (plan[n].stage == S_WB && plan[n].en) exp_count = (exp_count + 1) % (1 << CW);
        end
        check("end_stage", 32'(bus.pipeline_stage), 32'(S_IF));
        check("end_count", 32'(bus.instr_count), exp_count);
    endtask

    initial begin
        reset        = 1'b1;
        bus.enable   = 1'b1;
        bus.ex_len   = 2'd0;
        bus.mem_len  = 2'd0;
        bus.skip_mem = 1'b0;
        bus.mem_wait = 1'b0;
        #1;
        check("rst_stage", 32'(bus.pipeline_stage), 32'(S_IF));
        check("rst_index", 32'(bus.cycle_index), 0);
        check("rst_cycle_count", 32'(bus.cycle_count), 0);
        check("rst_fetch_en", 32'(bus.fetch_en), 1);
        check("rst_instr_done", 32'(bus.instr_done), 0);
        check("rst_instr_count", 32'(bus.instr_count), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Basic and RET-like instructions.
        run_instr(0, 0, 1'b0, 0, 0, 1'b0);
        run_instr(1, 1, 1'b0, 0, 0, 1'b0);

        // Reset asserted mid-EX takes effect before the next edge.
        bus.enable   = 1'b1;
        bus.mem_wait = 1'b0;
        bus.ex_len   = 2'd3;
        bus.mem_len  = 2'd0;
        bus.skip_mem = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("mid_ex_stage", 32'(bus.pipeline_stage), 32'(S_EX));
        check("mid_ex_index", 32'(bus.cycle_index), 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_stage", 32'(bus.pipeline_stage), 32'(S_IF));
        check("async_rst_index", 32'(bus.cycle_index), 0);
        check("async_rst_fetch_en", 32'(bus.fetch_en), 1);
        check("async_rst_instr_done", 32'(bus.instr_done), 0);
        check("async_rst_count", 32'(bus.instr_count), 0);
        @(posedge clk);
        #1;
        check("held_rst_stage", 32'(bus.pipeline_stage), 32'(S_IF));
        reset     = 1'b0;
        exp_count = 0;

        // Three wait cycles on the first MEM cycle of a two-cycle MEM.
        run_instr(0, 1, 1'b0, 3, 0, 1'b0);
        // Four frozen cycles in EX.
        run_instr(2, 0, 1'b0, 0, 4, 1'b0);
        // skip_mem: EX to WB only when the skip feature is built in.
        run_instr(1, 2, 1'b1, 0, 0, 1'b0);
        run_instr(0, 0, 1'b1, 0, 0, 1'b0);

        // Random instructions; together with the above this wraps the
        // 4-bit counter past 15.
        for (int i = 0; i < 20; i++) begin
            run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 0, 0, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
